// File: rtl/dmem_access_ctrl.sv
// Two-port data-memory access controller: round-robin arbitration, a fixed
// IDLE/ACCESS/RESP sequence, store byte-lane generation and load alignment/extension.
module dmem_access_ctrl #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  p0_req_valid,
   output logic                  p0_req_ready,
   input  logic                  p0_req_we,
   input  logic [DM_ADDRESS-1:0] p0_req_addr,
   input  logic [DATA_W-1:0]     p0_req_wdata,
   input  logic [2:0]            p0_req_funct3,
   output logic                  p0_resp_valid,
   output logic [DATA_W-1:0]     p0_resp_rdata,
   output logic                  p0_resp_err,
   input  logic                  p1_req_valid,
   output logic                  p1_req_ready,
   input  logic                  p1_req_we,
   input  logic [DM_ADDRESS-1:0] p1_req_addr,
   input  logic [DATA_W-1:0]     p1_req_wdata,
   input  logic [2:0]            p1_req_funct3,
   output logic                  p1_resp_valid,
   output logic [DATA_W-1:0]     p1_resp_rdata,
   output logic                  p1_resp_err,
   output logic [DM_ADDRESS-1:0] mem_raddr,
   output logic [DM_ADDRESS-1:0] mem_waddr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [3:0]            mem_wr,
   input  logic [DATA_W-1:0]     mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } state_t;

   state_t                state_q, state_d;
   logic                  ptr_q, ptr_d;
   logic                  port_q, port_d;
   logic                  we_q, we_d;
   logic [DM_ADDRESS-1:0] addr_q, addr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic [2:0]            funct3_q, funct3_d;
   logic                  err_q, err_d;

   logic                  grant_valid;
   logic                  grant_port;
   logic                  g_we;
   logic [DM_ADDRESS-1:0] g_addr;
   logic [DATA_W-1:0]     g_wdata;
   logic [2:0]            g_funct3;

   logic [DATA_W-1:0]     shifted;
   logic [DATA_W-1:0]     load_data;
   logic [DM_ADDRESS-1:0] word_addr;

   function automatic logic access_err(input logic we, input logic [2:0] f3,
                                       input logic [1:0] a);
      logic e;
      case (f3)
         3'b000:  e = 1'b0;
         3'b001:  e = a[0];
         3'b010:  e = (a != 2'b00);
         3'b100:  e = we;
         3'b101:  e = we | a[0];
         default: e = 1'b1;
      endcase
      return e;
   endfunction

   // On a tie the port that was not granted last wins.
   always_comb begin
      grant_valid = p0_req_valid | p1_req_valid;
      if (p0_req_valid && p1_req_valid) begin
         grant_port = ~ptr_q;
      end else begin
         grant_port = p1_req_valid;
      end
      g_we     = grant_port ? p1_req_we     : p0_req_we;
      g_addr   = grant_port ? p1_req_addr   : p0_req_addr;
      g_wdata  = grant_port ? p1_req_wdata  : p0_req_wdata;
      g_funct3 = grant_port ? p1_req_funct3 : p0_req_funct3;
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      port_d       = port_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      funct3_d     = funct3_q;
      err_d        = err_q;
      p0_req_ready = 1'b0;
      p1_req_ready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant_valid) begin
               p0_req_ready = ~grant_port & ~reset;
               p1_req_ready = grant_port & ~reset;
               ptr_d        = grant_port;
               port_d       = grant_port;
               we_d         = g_we;
               addr_d       = g_addr;
               wdata_d      = g_wdata;
               funct3_d     = g_funct3;
               err_d        = access_err(g_we, g_funct3, g_addr[1:0]);
               state_d      = ST_ACCESS;
            end
         end
         ST_ACCESS: state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      word_addr     = {addr_q[DM_ADDRESS-1:2], 2'b00};
      shifted       = mem_rdata >> {addr_q[1:0], 3'b000};
      load_data     = '0;
      mem_raddr     = '0;
      mem_waddr     = '0;
      mem_wdata     = '0;
      mem_wr        = '0;
      p0_resp_valid = 1'b0;
      p0_resp_rdata = '0;
      p0_resp_err   = 1'b0;
      p1_resp_valid = 1'b0;
      p1_resp_rdata = '0;
      p1_resp_err   = 1'b0;
      case (funct3_q)
         3'b000:  load_data = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
         3'b001:  load_data = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
         3'b010:  load_data = shifted;
         3'b100:  load_data = {{(DATA_W-8){1'b0}}, shifted[7:0]};
         3'b101:  load_data = {{(DATA_W-16){1'b0}}, shifted[15:0]};
         default: load_data = '0;
      endcase
      // Outputs are gated by reset so an in-flight store or response is squashed.
      if (!reset && state_q == ST_ACCESS) begin
         mem_raddr = word_addr;
         mem_waddr = word_addr;
         if (we_q && !err_q) begin
            case (funct3_q[1:0])
               2'b00: begin
                  mem_wr    = 4'b0001 << addr_q[1:0];
                  mem_wdata = {4{wdata_q[7:0]}};
               end
               2'b01: begin
                  mem_wr    = 4'b0011 << addr_q[1:0];
                  mem_wdata = {2{wdata_q[15:0]}};
               end
               default: begin
                  mem_wr    = 4'b1111;
                  mem_wdata = wdata_q;
               end
            endcase
         end
      end
      if (!reset && state_q == ST_RESP) begin
         if (port_q) begin
            p1_resp_valid = 1'b1;
            p1_resp_err   = err_q;
            p1_resp_rdata = (we_q || err_q) ? '0 : load_data;
         end else begin
            p0_resp_valid = 1'b1;
            p0_resp_err   = err_q;
            p0_resp_rdata = (we_q || err_q) ? '0 : load_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         ptr_q    <= 1'b1;
         port_q   <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         funct3_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         port_q   <= port_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         funct3_q <= funct3_d;
         err_q    <= err_d;
      end
   end

endmodule
